pico_mem_responder: RTL

//  Wait-state memory responder for the picorv32 native memory interface (mem_valid/mem_ready).

---
 rtl/pico_mem_responder_pkg.sv | 13 +
 rtl/pico_mem_responder_if.sv | 22 ++
 rtl/pico_mem_responder_sram.sv | 44 ++++
 rtl/pico_mem_responder.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/pico_mem_responder_pkg.sv
// Shared types and constants for the wait-state memory responder.
package pico_mem_pkg;

  localparam int WAIT_W = 4;
  localparam logic [31:0] RD_ERR_DATA = 32'h0000_0000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

endpackage

// File: rtl/pico_mem_responder_if.sv
// picorv32 native memory bus: the CPU drives requests, the responder answers with ready/rdata.
interface pico_mem_if;

  logic        mem_valid;
  logic        mem_instr;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ready;
  logic [31:0] mem_rdata;

  modport master (
    output mem_valid, mem_instr, mem_addr, mem_wdata, mem_wstrb,
    input  mem_ready, mem_rdata
  );

  modport slave (
    input  mem_valid, mem_instr, mem_addr, mem_wdata, mem_wstrb,
    output mem_ready, mem_rdata
  );

endinterface

// File: rtl/pico_mem_responder_sram.sv
// Word-organised array with per-byte write enables and a registered read port that
// returns RD_ERR_DATA on every cycle it is not asked to read.
module pico_word_sram
  import pico_mem_pkg::*;
#(
  parameter int unsigned WORDS = 32,
  parameter int unsigned AW    = 5
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          we_i,
  input  logic          re_i,
  input  logic [3:0]    be_i,
  input  logic [AW-1:0] idx_i,
  input  logic [31:0]   wdata_i,
  output logic [31:0]   rdata_o
);

  logic [31:0] mem_q [WORDS];
  logic [31:0] rdata_q;

  // Byte-lane writes; contents deliberately survive reset.
  always_ff @(posedge clk_i) begin
    for (int b = 0; b < 4; b++) begin
      if (we_i && be_i[b]) begin
        mem_q[idx_i][8*b +: 8] <= wdata_i[8*b +: 8];
      end
    end
  end

  // Read register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rdata_q <= RD_ERR_DATA;
    end else if (re_i) begin
      rdata_q <= mem_q[idx_i];
    end else begin
      rdata_q <= RD_ERR_DATA;
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/pico_mem_responder.sv
// Wait-state responder for the picorv32 native memory interface with sticky
// out-of-range / protocol error flags and an instruction-fetch counter.
module pico_mem_responder
  import pico_mem_pkg::*;
#(
  parameter int unsigned WORDS       = 32,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  pico_mem_if.slave   mem,
  output logic        err_oob_o,
  output logic        err_proto_o,
  output logic [15:0] fetch_count_o
);

  localparam int unsigned        AW        = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [31:0]        SPAN      = 32'(WORDS * 4);
  localparam logic [WAIT_W-1:0]  WAIT_INIT = WAIT_W'(WAIT_CYCLES);
  localparam logic [WAIT_W-1:0]  CNT_ONE   = WAIT_W'(1);

  state_e            state_q, state_d;
  logic [WAIT_W-1:0] cnt_q, cnt_d;
  logic [31:0]       addr_q, addr_d, wdata_q, wdata_d;
  logic [3:0]        wstrb_q, wstrb_d;
  logic              instr_q, instr_d, ready_q, ready_d;
  logic              oob_q, oob_d, proto_q, proto_d;
  logic [15:0]       fcnt_q, fcnt_d;

  logic [31:0]       req_addr_s, req_wdata_s, offset_s, sram_rdata_s;
  logic [3:0]        req_wstrb_s;
  logic              req_instr_s, in_range_s, enter_resp_s, sram_we_s, sram_re_s;
  logic [AW-1:0]     idx_s;

  // With zero wait states the access is served straight from the bus in IDLE.
  assign req_addr_s  = (state_q == IDLE) ? mem.mem_addr  : addr_q;
  assign req_wdata_s = (state_q == IDLE) ? mem.mem_wdata : wdata_q;
  assign req_wstrb_s = (state_q == IDLE) ? mem.mem_wstrb : wstrb_q;
  assign req_instr_s = (state_q == IDLE) ? mem.mem_instr : instr_q;
  assign offset_s    = req_addr_s - BASE_ADDR;
  assign in_range_s  = (offset_s < SPAN);
  assign idx_s       = offset_s[AW+1:2];

  // Next-state, request capture and error/counter update.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    wstrb_d      = wstrb_q;
    instr_d      = instr_q;
    ready_d      = 1'b0;
    oob_d        = oob_q;
    proto_d      = proto_q;
    fcnt_d       = fcnt_q;
    enter_resp_s = 1'b0;
    sram_we_s    = 1'b0;
    sram_re_s    = 1'b0;
    case (state_q)
      IDLE: begin
        if (mem.mem_valid) begin
          addr_d  = mem.mem_addr;
          wdata_d = mem.mem_wdata;
          wstrb_d = mem.mem_wstrb;
          instr_d = mem.mem_instr;
          cnt_d   = WAIT_INIT;
          if (WAIT_INIT == '0) begin
            enter_resp_s = 1'b1;
          end else begin
            state_d = WAIT;
          end
        end else begin
          state_d = IDLE;
        end
      end
      WAIT: begin
        if (!mem.mem_valid) begin
          state_d = IDLE;
          proto_d = 1'b1;
        end else begin
          if ((mem.mem_addr != addr_q) || (mem.mem_wdata != wdata_q) ||
              (mem.mem_wstrb != wstrb_q)) begin
            proto_d = 1'b1;
          end else begin
            proto_d = proto_q;
          end
          cnt_d = cnt_q - CNT_ONE;
          if (cnt_q == CNT_ONE) begin
            enter_resp_s = 1'b1;
          end else begin
            state_d = WAIT;
          end
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    if (enter_resp_s) begin
      state_d = RESP;
      ready_d = 1'b1;
      if (in_range_s) begin
        sram_we_s = (req_wstrb_s != 4'b0000);
        sram_re_s = (req_wstrb_s == 4'b0000);
      end else begin
        oob_d = 1'b1;
      end
      if (req_instr_s && (fcnt_q != 16'hFFFF)) begin
        fcnt_d = fcnt_q + 16'd1;
      end else begin
        fcnt_d = fcnt_q;
      end
    end else begin
      ready_d = 1'b0;
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= 32'h0;
      wdata_q <= 32'h0;
      wstrb_q <= 4'b0000;
      instr_q <= 1'b0;
      ready_q <= 1'b0;
      oob_q   <= 1'b0;
      proto_q <= 1'b0;
      fcnt_q  <= 16'h0000;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wstrb_q <= wstrb_d;
      instr_q <= instr_d;
      ready_q <= ready_d;
      oob_q   <= oob_d;
      proto_q <= proto_d;
      fcnt_q  <= fcnt_d;
    end
  end

  pico_word_sram #(.WORDS(WORDS), .AW(AW)) u_sram (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .we_i    (sram_we_s),
    .re_i    (sram_re_s),
    .be_i    (req_wstrb_s),
    .idx_i   (idx_s),
    .wdata_i (req_wdata_s),
    .rdata_o (sram_rdata_s)
  );

  assign mem.mem_ready  = ready_q;
  assign mem.mem_rdata  = sram_rdata_s;
  assign err_oob_o      = oob_q;
  assign err_proto_o    = proto_q;
  assign fetch_count_o  = fcnt_q;

endmodule
